// File: rtl/if_fetch_ctrl_pkg.sv
// Shared fetch-stage constants and the prefetch queue entry layout.
package if_fetch_ctrl_pkg;

    localparam int unsigned IF_ADDR_W = 16;
    localparam int unsigned IF_INST_W = 32;

    // One prefetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [IF_INST_W-1:0] inst;
        logic [IF_ADDR_W-1:0] pc;
    } if_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous prefetch FIFO: push at tail, pop at head, flush empties it.
// Head entry is always presented; it is meaningful only while o_count != 0.
module if_fetch_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Flush overrides both push and pop; push into a full queue is ignored.
    assign w_push = i_push && !i_flush && (r_count != CNT_W'(DEPTH));
    assign w_pop  = i_pop  && !i_flush && (r_count != '0);

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Entry storage; cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: issues word-aligned fetches under a credit
// limit, queues returned words with their PC, and hands them to decode.
// A redirect flushes the queue and discards responses of the old stream.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int unsigned        ADDR_W   = IF_ADDR_W,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect_valid,
    input  logic [ADDR_W-1:0]    redirect_pc,
    input  logic                 id_ready,
    output logic                 if_valid,
    output logic [IF_INST_W-1:0] if_inst,
    output logic [ADDR_W-1:0]    if_pc,
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [IF_INST_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = IF_INST_W + ADDR_W;

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_resp_pc;
    logic [CNT_W-1:0]   r_outstanding;
    logic [CNT_W-1:0]   r_discard;

    logic [CNT_W-1:0]   w_count;
    logic [ENTRY_W-1:0] w_head;
    logic [CNT_W:0]     w_credit_used;
    logic [ADDR_W-1:0]  w_redirect_pc;
    logic [CNT_W-1:0]   w_old_in_flight;
    logic               w_grant;
    logic               w_push;
    logic               w_pop;
    logic               w_unused_pc_lsbs;

    assign w_redirect_pc    = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign w_unused_pc_lsbs = ^redirect_pc[1:0];

    // Queued words plus words still in flight may never exceed the queue size,
    // so a returning response always has a free slot.
    assign w_credit_used = {1'b0, w_count} + {1'b0, r_outstanding};
    assign mem_req       = !rst && !redirect_valid && (w_credit_used < (CNT_W+1)'(DEPTH));
    assign mem_addr      = r_fetch_pc;
    assign w_grant       = mem_req && mem_gnt;

    // Responses are kept only when no old-stream words remain to be dropped
    // and no redirect is killing the current stream this cycle.
    assign w_push = mem_rvalid && !redirect_valid && (r_discard == '0);

    assign if_valid = (w_count != '0) && !redirect_valid;
    assign w_pop    = if_valid && id_ready;
    assign if_inst  = w_head[ENTRY_W-1:ADDR_W];
    assign if_pc    = w_head[ADDR_W-1:0];

    // Requests that are still owed a response, excluding one returning now.
    assign w_old_in_flight = r_outstanding - CNT_W'(mem_rvalid);

    // Issue PC and response-tag PC; both restart at the redirect target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
            r_resp_pc  <= w_redirect_pc;
        end else begin
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + ADDR_W'(4);
            end
        end
    end

    // Outstanding-request and discard accounting. No grant can occur in a
    // redirect cycle, so everything still in flight afterwards is stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
            r_discard     <= '0;
        end else if (redirect_valid) begin
            r_outstanding <= w_old_in_flight;
            r_discard     <= w_old_in_flight;
        end else begin
            if (w_grant && !mem_rvalid) begin
                r_outstanding <= r_outstanding + CNT_W'(1);
            end else if (mem_rvalid && !w_grant) begin
                r_outstanding <= r_outstanding - CNT_W'(1);
            end
            if (mem_rvalid && (r_discard != '0)) begin
                r_discard <= r_discard - CNT_W'(1);
            end
        end
    end

    if_fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({mem_rdata, r_resp_pc}),
        .o_head  (w_head),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: a directed vector table on a RESET_PC=0xFFF8
// instance, plus directed and random sequences on a RESET_PC=0 instance
// checked against a stream-level reference model.
module tb_if_fetch_ctrl;
    import if_fetch_ctrl_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Main instance (RESET_PC = 0)
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc    = '0;
    logic        id_ready       = 1'b0;
    logic        mem_gnt        = 1'b0;
    logic        mem_rvalid     = 1'b0;
    logic [31:0] mem_rdata      = '0;
    logic        if_valid, mem_req;
    logic [31:0] if_inst;
    logic [15:0] if_pc, mem_addr;

    // Wrap-around instance (RESET_PC = 0xFFF8)
    logic        redirect_valid2 = 1'b0;
    logic [15:0] redirect_pc2    = '0;
    logic        id_ready2       = 1'b0;
    logic        mem_gnt2        = 1'b0;
    logic        mem_rvalid2     = 1'b0;
    logic [31:0] mem_rdata2      = '0;
    logic        if_valid2, mem_req2;
    logic [31:0] if_inst2;
    logic [15:0] if_pc2, mem_addr2;

    always #5 clk = ~clk;

    if_fetch_ctrl #(.ADDR_W(16), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    if_fetch_ctrl #(.ADDR_W(16), .DEPTH(DEPTH), .RESET_PC(16'hFFF8)) dut2 (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .id_ready(id_ready2), .if_valid(if_valid2), .if_inst(if_inst2), .if_pc(if_pc2),
        .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_gnt(mem_gnt2),
        .mem_rvalid(mem_rvalid2), .mem_rdata(mem_rdata2)
    );

    int n_chk = 0;
    int n_err = 0;

    // Memory image: each word encodes its own address.
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model of the fetch stream ----------------
    typedef struct {
        logic [15:0] addr;
        int          epoch;
        int          due;
    } infl_t;

    infl_t       infl[$];     // requests granted, response not yet returned
    if_entry_t   qm[$];       // words that decode should see, in order
    logic [15:0] fpc;         // next address the fetcher must request
    int          epoch = 0;   // bumps on every redirect; older words are stale
    int          cyc = 0;
    int          lat_min = 1, lat_max = 1;
    int          n_pop = 0, n_dut_grant = 0;
    logic [15:0] last_pop_pc;

    // One clock cycle of stimulus, comparison and model update.
    task automatic step(input bit redir, input logic [15:0] rpc, input bit rdy, input bit gnt);
        bit        rv;
        bit        exp_req;
        bit        exp_valid;
        int        lat;
        infl_t     r;
        if_entry_t e;
        @(negedge clk);
        rv = (infl.size() > 0) && (infl[0].due <= cyc);
        redirect_valid = redir;
        redirect_pc    = rpc;
        id_ready       = rdy;
        mem_gnt        = gnt;
        mem_rvalid     = rv;
        mem_rdata      = rv ? mem_word(infl[0].addr) : $urandom;
        #1;
        exp_req = !redir && ((qm.size() + infl.size()) < DEPTH);
        check("mem_req", 32'(mem_req), 32'(exp_req));
        if (exp_req) check("mem_addr", 32'(mem_addr), 32'(fpc));
        exp_valid = (qm.size() != 0) && !redir;
        check("if_valid", 32'(if_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("if_pc", 32'(if_pc), 32'(qm[0].pc));
            check("if_inst", if_inst, qm[0].inst);
        end
        if (if_valid && rdy) begin
            n_pop++;
            last_pop_pc = if_pc;
        end
        if (mem_req && gnt) n_dut_grant++;

        if (exp_valid && rdy) e = qm.pop_front();
        if (rv) begin
            r = infl.pop_front();
            if (r.epoch == epoch && !redir) begin
                e.inst = mem_word(r.addr);
                e.pc   = r.addr;
                qm.push_back(e);
            end
        end
        if (exp_req && gnt) begin
            lat = $urandom_range(lat_max, lat_min);
            infl.push_back('{fpc, epoch, cyc + lat});
            fpc = fpc + 16'd4;
        end
        if (redir) begin
            qm.delete();
            fpc = {rpc[15:2], 2'b00};
            epoch++;
        end
        cyc++;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; id_ready = 1'b0;
        mem_gnt2 = 1'b0; mem_rvalid2 = 1'b0; id_ready2 = 1'b0;
        #1;
        check("rst_if_valid", 32'(if_valid), 32'(0));
        check("rst_if_inst", if_inst, 32'(0));
        check("rst_if_pc", 32'(if_pc), 32'(0));
        check("rst_mem_req", 32'(mem_req), 32'(0));
        check("rst_mem_req2", 32'(mem_req2), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        qm.delete();
        infl.delete();
        fpc = 16'h0000;
        cyc = 0;
    endtask

    // ---------------- vector table for the wrap-around instance ----------------
    typedef struct {
        bit          gnt;
        bit          rv;
        bit          rdy;
        bit          ereq;
        logic [15:0] eaddr;
        bit          evalid;
        logic [15:0] epc;
    } vec_t;

    vec_t        tbl[12];
    logic [15:0] q2[$];

    initial begin
        int p0;
        int g0;

        // gnt, rv, rdy | req, addr, valid, pc
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'hFFF8, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'hFFF8, 1'b0, 16'h0000};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFC, 1'b0, 16'h0000};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 16'hFFF8};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0004, 1'b1, 16'hFFFC};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0008, 1'b1, 16'hFFFC};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h000C, 1'b1, 16'h0000};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 1'b1, 16'h0004};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0014, 1'b1, 16'h0008};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0014, 1'b1, 16'h000C};

        do_reset();

        // Table: RESET_PC wrap, credit stall when full, held request.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            mem_gnt2    = tbl[i].gnt;
            mem_rvalid2 = tbl[i].rv;
            id_ready2   = tbl[i].rdy;
            mem_rdata2  = (tbl[i].rv && q2.size() > 0) ? mem_word(q2[0]) : 32'h0;
            #1;
            check("tbl_mem_req", 32'(mem_req2), 32'(tbl[i].ereq));
            if (tbl[i].ereq) check("tbl_mem_addr", 32'(mem_addr2), 32'(tbl[i].eaddr));
            check("tbl_if_valid", 32'(if_valid2), 32'(tbl[i].evalid));
            if (tbl[i].evalid) begin
                check("tbl_if_pc", 32'(if_pc2), 32'(tbl[i].epc));
                check("tbl_if_inst", if_inst2, mem_word(tbl[i].epc));
            end
            if (tbl[i].ereq && tbl[i].gnt) q2.push_back(tbl[i].eaddr);
            if (tbl[i].rv && q2.size() > 0) void'(q2.pop_front());
        end
        mem_gnt2 = 1'b0; mem_rvalid2 = 1'b0; id_ready2 = 1'b0;

        // Steady state, single-cycle memory: one instruction per cycle.
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (4) step(1'b0, 16'h0, 1'b1, 1'b1);
        p0 = n_pop;
        repeat (8) step(1'b0, 16'h0, 1'b1, 1'b1);
        check("throughput", 32'(n_pop - p0), 32'(8));

        // Decode stalled: exactly DEPTH requests, then drain in order.
        do_reset();
        g0 = n_dut_grant;
        repeat (10) step(1'b0, 16'h0, 1'b0, 1'b1);
        check("credit_grants", 32'(n_dut_grant - g0), 32'(DEPTH));
        p0 = n_pop;
        repeat (10) step(1'b0, 16'h0, 1'b1, 1'b1);
        check("drain_count", 32'(n_pop - p0), 32'(10));

        // Redirect with three requests in flight (latency 4).
        do_reset();
        lat_min = 4; lat_max = 4;
        repeat (3) step(1'b0, 16'h0, 1'b1, 1'b1);
        step(1'b1, 16'h0102, 1'b1, 1'b1);
        p0 = n_pop;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b1);
            if (n_pop != p0) break;
        end
        check("redir_timeout", 32'(n_pop != p0), 32'(1));
        check("redir_first_pc", 32'(last_pop_pc), 32'h0100);

        // Redirect coinciding with an old response and a held head.
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (3) step(1'b0, 16'h0, 1'b0, 1'b1);
        p0 = n_pop;
        step(1'b1, 16'h0040, 1'b1, 1'b1);
        check("redir_no_pop", 32'(n_pop - p0), 32'(0));
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b1);
            if (n_pop != p0) break;
        end
        check("redir2_first_pc", 32'(last_pop_pc), 32'h0040);

        // Back-to-back redirects: the last one wins.
        lat_min = 2; lat_max = 3;
        repeat (3) step(1'b0, 16'h0, 1'b1, 1'b1);
        step(1'b1, 16'h0200, 1'b1, 1'b1);
        step(1'b1, 16'h0303, 1'b1, 1'b1);
        p0 = n_pop;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b1);
            if (n_pop != p0) break;
        end
        check("b2b_first_pc", 32'(last_pop_pc), 32'h0300);

        // Reset mid-stream with requests in flight and a non-empty queue.
        lat_min = 3; lat_max = 3;
        repeat (6) step(1'b0, 16'h0, 1'b0, 1'b1);
        check("pre_rst_if_valid", 32'(if_valid), 32'(1));
        do_reset();
        lat_min = 1; lat_max = 1;
        p0 = n_pop;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b1);
            if (n_pop != p0) break;
        end
        check("post_rst_first_pc", 32'(last_pop_pc), 32'h0000);

        // Random traffic against the reference model.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 31) == 0), 16'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
